seg7_word_decoder: RTL and testbench
====================================

Name: seg7_word_decoder

Overview:
Reverse of the segment driver. Accepts a stream of 7-segment patterns, one digit per handshake, in the same active-low form the display decoder drives onto HEXn. Each pattern is mapped back to its 4-bit hex value, and DIGITS values are packed into one word presented on a valid/ready output. Used to loop back display outputs for self-check and to parse segment-coded data from other blocks.

Parameters:
DIGITS, 4, number of digits packed per output word (legal range 1..8).

Ports:
clock  input  1  system clock, all state updates on rising edge.
resetn  input  1  synchronous active-low reset, sampled on rising edge of clock.
seg_in  input  7  active-low segment pattern; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
seg_valid  input  1  seg_in holds a digit this cycle.
seg_ready  output  1  block accepts a digit this cycle.
clear  input  1  discard the partially collected word.
word_out  output  4*DIGITS  packed hex word; first-received digit in the most significant nibble.
word_valid  output  1  word_out holds a complete word.
word_ready  input  1  consumer takes word_out.
word_err  output  1  at least one digit in the presented word was an illegal pattern.
err_count  output  8  saturating count of illegal patterns since reset.

Behaviour:
- Reset (resetn=0 at edge): state=COLLECT, digit count=0, word_out=0, word_valid=0, word_err=0, err_count=0. seg_ready=0 while resetn=0.
- Decode table, seg_in value to nibble: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->b, 0x46->C, 0x21->d, 0x06->E, 0x0E->F.
  - Any other pattern, including blank 0x7F, is illegal.
  - An illegal pattern inserts nibble 0, sets word_err for the current word, and increments err_count. err_count holds at 255.
- seg_ready is combinational: 1 when state=COLLECT, clear=0 and resetn=1; otherwise 0.
- A digit is accepted when seg_valid=1 and seg_ready=1 at the edge.
  - On acceptance, word_out shifts left by 4 and the decoded nibble loads into bits [3:0].
  - Digit count increments on each acceptance.
- State COLLECT:
  - Accepting the digit that brings the count to DIGITS moves to PRESENT. word_valid=1 from the next cycle, so latency is 1 cycle after the final handshake.
  - clear=1: count=0, word_out=0, word_err=0, next state COLLECT. No digit is accepted that cycle. err_count is not affected.
- State PRESENT:
  - word_out, word_valid=1 and word_err are held stable until word_ready=1.
  - On word_valid and word_ready at the edge: next cycle word_valid=0, count=0, word_err=0, state=COLLECT. word_out keeps the old value until the next accepted digit shifts it.
  - clear is ignored in PRESENT.
  - seg_valid is ignored in PRESENT; the upstream source must hold its data.
- Throughput: at most one word per DIGITS+1 cycles (one bubble cycle for the output handshake).
- Mid-operation reset: any partial or presented word is lost and all outputs return to their reset values on the next edge.
- Changes to seg_in while seg_valid=0 have no effect.
- DIGITS=1: every accepted digit moves directly to PRESENT.

Test Plan:
- DIGITS=4, send 0x79, 0x24, 0x30, 0x19 back-to-back with word_ready=1 -> word_valid=1 one cycle after the 4th handshake, word_out=0x1234, word_err=0; word_valid drops the following cycle.
- Send all 16 legal patterns in order 0..F (4 words, DIGITS=4) -> words 0x0123, 0x4567, 0x89AB, 0xCDEF; err_count=0.
- Send 0x40, 0x7F, 0x0E, 0x00 -> word_out=0x00F8, word_err=1, err_count=1. Next word 0x79x4 -> 0x1111, word_err=0.
- Hold word_ready=0 for 10 cycles after a word completes while seg_valid=1 with new data -> seg_ready=0 throughout, word_out stable. Release word_ready -> the next digit is accepted 1 cycle after word_valid falls.
- Accept 2 digits, assert clear together with seg_valid -> seg_ready=0 that cycle. Then send 0x08, 0x03, 0x46, 0x21 -> word_out=0xABCD.
- Pulse resetn=0 after 3 digits have been accepted -> the next edge gives word_valid=0, word_out=0, err_count=0. Then send 4 digits -> a correct fresh word. Also send 300 illegal patterns -> err_count saturates at 255.

Source files
------------

// File: rtl/seg7_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_word_decoder
// Description : Converts a stream of active-low 7-segment patterns back into
//               4-bit hex values and packs DIGITS of them into one word.
//               The first digit received lands in the most significant nibble.
//               Illegal patterns load nibble 0, flag the word, and bump a
//               saturating error counter.
// Ports       :
//   clock      in   system clock, rising-edge
//   resetn     in   synchronous active-low reset
//   seg_in     in   [6:0] active-low segments, bit0=a ... bit6=g
//   seg_valid  in   seg_in carries a digit
//   seg_ready  out  digit can be accepted this cycle
//   clear      in   drop the partially collected word
//   word_out   out  [4*DIGITS-1:0] packed hex word
//   word_valid out  word_out holds a complete word
//   word_ready in   consumer takes word_out
//   word_err   out  presented word contains at least one illegal digit
//   err_count  out  [7:0] saturating illegal-pattern count since reset
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_word_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [6:0]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  word_err,
    output logic [7:0]            err_count
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DIGITS - 1);
    localparam logic [7:0]       c_err_max  = 8'hFF;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [4*DIGITS-1:0] r_word;
    logic [4*DIGITS-1:0] w_shifted;
    logic                r_word_err;
    logic [7:0]          r_err_count;

    logic [3:0]          w_nib;
    logic                w_illegal;
    logic                w_seg_ready;
    logic                w_accept;
    logic                w_handshake;

    // Pattern-to-nibble lookup; anything not in the table is illegal.
    always_comb begin
        w_nib     = 4'h0;
        w_illegal = 1'b0;
        case (seg_in)
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'hA;
            7'h03:   w_nib = 4'hB;
            7'h46:   w_nib = 4'hC;
            7'h21:   w_nib = 4'hD;
            7'h06:   w_nib = 4'hE;
            7'h0E:   w_nib = 4'hF;
            default: w_illegal = 1'b1;
        endcase
    end

    // A single-digit word has nothing to shift out, so the new nibble is the word.
    generate
        if (DIGITS == 1) begin : g_shift_single
            assign w_shifted = w_nib;
        end else begin : g_shift_multi
            assign w_shifted = {r_word[4*DIGITS-5:0], w_nib};
        end
    endgenerate

    // clear takes priority over a digit in the same cycle by withholding ready.
    assign w_seg_ready = resetn && (r_state == S_COLLECT) && !clear;
    assign w_accept    = seg_valid && w_seg_ready;
    assign w_handshake = (r_state == S_PRESENT) && word_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_accept && (r_count == c_last_idx)) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (word_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count    <= '0;
            r_word     <= '0;
            r_word_err <= 1'b0;
        end else if (r_state == S_COLLECT) begin
            if (clear) begin
                r_count    <= '0;
                r_word     <= '0;
                r_word_err <= 1'b0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
                r_word  <= w_shifted;
                if (w_illegal) begin
                    r_word_err <= 1'b1;
                end
            end
        end else if (w_handshake) begin
            // The presented word stays on word_out until the next digit shifts it.
            r_count    <= '0;
            r_word_err <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_err_count <= 8'h00;
        end else if (w_accept && w_illegal && (r_err_count != c_err_max)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign seg_ready  = w_seg_ready;
    assign word_out   = r_word;
    assign word_valid = (r_state == S_PRESENT);
    assign word_err   = r_word_err;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_seg7_word_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_word_decoder
// Description : Self-checking bench for seg7_word_decoder (DIGITS=4).
//               Directed scenarios plus a randomized run, all compared
//               against a behavioural model of the word assembler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_word_decoder;

    localparam int DIGITS = 4;

    logic        clk;
    logic        resetn;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic        clear;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        word_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Legal display patterns indexed by the hex value they show.
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model state
    bit m_present;
    int m_n;
    int m_word;
    bit m_err;
    int m_errcnt;

    seg7_word_decoder #(.DIGITS(DIGITS)) dut (
        .clock      (clk),
        .resetn     (resetn),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .clear      (clear),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_err   (word_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the hex value of a pattern, or -1 if it is not a legal digit.
    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 16; k++) begin
            if (lut[k] == p) return k;
        end
        return -1;
    endfunction

    task automatic set_in(input logic sv, input logic [6:0] si, input logic cl, input logic wr);
        seg_valid  = sv;
        seg_in     = si;
        clear      = cl;
        word_ready = wr;
        #1;
    endtask

    // Advance the model by the rules for the inputs now applied, then clock the DUT.
    task automatic tick();
        int v;
        if (!resetn) begin
            m_present = 0; m_n = 0; m_word = 0; m_err = 0; m_errcnt = 0;
        end else if (m_present) begin
            if (word_ready) begin
                m_present = 0; m_n = 0; m_err = 0;
            end
        end else if (clear) begin
            m_n = 0; m_word = 0; m_err = 0;
        end else if (seg_valid) begin
            v = lookup(seg_in);
            if (v < 0) begin
                v = 0;
                m_err = 1;
                if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
            end
            m_word = (m_word * 16 + v) % 65536;
            m_n = m_n + 1;
            if (m_n == DIGITS) m_present = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_in(0, 7'h7F, 0, 0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_in(1, 7'h79, 0, 1);
        tick();
        n_checks++;
        if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_seg_ready: got %b expected 0", seg_ready); end
        tick();
        n_checks++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
        n_checks++;
        if (word_out !== 16'h0000) begin n_fail++; $display("FAIL reset_word_out: got %h expected 0000", word_out); end
        n_checks++;
        if (word_err !== 1'b0) begin n_fail++; $display("FAIL reset_word_err: got %b expected 0", word_err); end
        n_checks++;
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_basic_word();
        logic [6:0] pats [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, pats[i], 0, 1);
            n_checks++;
            if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_seg_ready[%0d]: got %b expected 1", i, seg_ready); end
            tick();
        end
        n_checks++;
        if (word_valid !== 1'b1) begin n_fail++; $display("FAIL basic_word_valid: got %b expected 1", word_valid); end
        n_checks++;
        if (word_out !== 16'h1234) begin n_fail++; $display("FAIL basic_word_out: got %h expected 1234", word_out); end
        n_checks++;
        if (word_err !== 1'b0) begin n_fail++; $display("FAIL basic_word_err: got %b expected 0", word_err); end
        set_in(0, 7'h7F, 0, 1);
        tick();
        n_checks++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0", word_valid); end
    endtask

    task automatic test_all_legal();
        logic [15:0] exp_words [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        int i = 0;
        int w = 0;
        int guard = 0;
        logic acc;
        do_reset();
        while (i < 16 && guard < 100) begin
            set_in(1, lut[i], 0, 1);
            acc = seg_ready;
            tick();
            guard++;
            if (acc) i++;
            if (word_valid === 1'b1 && w < 4) begin
                n_checks++;
                if (word_out !== exp_words[w]) begin n_fail++; $display("FAIL legal_word[%0d]: got %h expected %h", w, word_out, exp_words[w]); end
                w++;
            end
        end
        set_in(0, 7'h7F, 0, 1);
        tick();
        n_checks++;
        if (w != 4) begin n_fail++; $display("FAIL legal_word_count: got %0d expected 4", w); end
        n_checks++;
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL legal_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_illegal();
        logic [6:0] pats [4] = '{7'h40, 7'h7F, 7'h0E, 7'h00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, pats[i], 0, 0);
            tick();
        end
        n_checks++;
        if (word_out !== 16'h00F8) begin n_fail++; $display("FAIL illegal_word_out: got %h expected 00f8", word_out); end
        n_checks++;
        if (word_err !== 1'b1) begin n_fail++; $display("FAIL illegal_word_err: got %b expected 1", word_err); end
        n_checks++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_err_count: got %0d expected 1", err_count); end
        set_in(0, 7'h7F, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 7'h79, 0, 0);
            tick();
        end
        n_checks++;
        if (word_out !== 16'h1111) begin n_fail++; $display("FAIL illegal_next_word: got %h expected 1111", word_out); end
        n_checks++;
        if (word_err !== 1'b0) begin n_fail++; $display("FAIL illegal_next_err: got %b expected 0", word_err); end
        n_checks++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_count_hold: got %0d expected 1", err_count); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, lut[i+6], 0, 0);
            tick();
        end
        held = word_out;
        n_checks++;
        if (held !== 16'h6789) begin n_fail++; $display("FAIL bp_word: got %h expected 6789", held); end
        for (int c = 0; c < 10; c++) begin
            set_in(1, lut[$urandom_range(0, 15)], 0, 0);
            n_checks++;
            if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL bp_seg_ready[%0d]: got %b expected 0", c, seg_ready); end
            tick();
            n_checks++;
            if (word_out !== held || word_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b expected %h/1", c, word_out, word_valid, held);
            end
        end
        set_in(1, lut[5], 0, 1);
        tick();
        n_checks++;
        if (word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", word_valid); end
        set_in(1, lut[5], 0, 1);
        n_checks++;
        if (seg_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", seg_ready); end
        tick();
        n_checks++;
        if (word_out !== 16'h7895) begin n_fail++; $display("FAIL bp_next_digit: got %h expected 7895", word_out); end
    endtask

    task automatic test_clear();
        logic [6:0] pats [4] = '{7'h08, 7'h03, 7'h46, 7'h21};
        do_reset();
        set_in(1, lut[9], 0, 0); tick();
        set_in(1, lut[9], 0, 0); tick();
        set_in(1, lut[3], 1, 0);
        n_checks++;
        if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL clear_seg_ready: got %b expected 0", seg_ready); end
        tick();
        n_checks++;
        if (word_out !== 16'h0000) begin n_fail++; $display("FAIL clear_word_out: got %h expected 0000", word_out); end
        for (int i = 0; i < 4; i++) begin
            set_in(1, pats[i], 0, 0);
            tick();
        end
        n_checks++;
        if (word_out !== 16'hABCD || word_valid !== 1'b1) begin
            n_fail++; $display("FAIL clear_next_word: got %h/%b expected abcd/1", word_out, word_valid);
        end
    endtask

    task automatic test_midreset();
        int acc_n = 0;
        int guard = 0;
        logic acc;
        do_reset();
        set_in(1, 7'h7F, 0, 0); tick();
        set_in(1, lut[2], 0, 0); tick();
        set_in(1, lut[3], 0, 0); tick();
        resetn = 1'b0;
        set_in(1, lut[4], 0, 0);
        n_checks++;
        if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_seg_ready: got %b expected 0", seg_ready); end
        tick();
        n_checks++;
        if (word_valid !== 1'b0 || word_out !== 16'h0000 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b/%h/%0d expected 0/0000/0", word_valid, word_out, err_count);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1, lut[i+5], 0, 0);
            tick();
        end
        n_checks++;
        if (word_out !== 16'h5678 || word_valid !== 1'b1 || word_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_fresh_word: got %h/%b/%b expected 5678/1/0", word_out, word_valid, word_err);
        end
        set_in(0, 7'h7F, 0, 1);
        tick();
        while (acc_n < 300 && guard < 1000) begin
            set_in(1, 7'h7F, 0, 1);
            acc = seg_ready;
            tick();
            guard++;
            if (acc) acc_n++;
        end
        n_checks++;
        if (acc_n != 300) begin n_fail++; $display("FAIL sat_timeout: got %0d accepted expected 300", acc_n); end
        n_checks++;
        if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err_count: got %0d expected 255", err_count); end
        n_checks++;
        if (err_count !== 8'(m_errcnt)) begin n_fail++; $display("FAIL sat_model: got %0d expected %0d", err_count, m_errcnt); end
    endtask

    task automatic test_random();
        logic       sv;
        logic       cl;
        logic       wr;
        logic [6:0] si;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sv = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 11) == 0);
            wr = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0) si = 7'($urandom_range(0, 127));
            else                           si = lut[$urandom_range(0, 15)];
            set_in(sv, si, cl, wr);
            n_checks++;
            if (seg_ready !== (!m_present && !cl)) begin
                n_fail++; $display("FAIL rand_seg_ready[%0d]: got %b expected %b", c, seg_ready, (!m_present && !cl));
            end
            n_checks++;
            if (word_valid !== m_present || word_out !== 16'(m_word) || word_err !== m_err || err_count !== 8'(m_errcnt)) begin
                n_fail++;
                $display("FAIL rand_outputs[%0d]: got v=%b w=%h e=%b n=%0d expected v=%b w=%h e=%b n=%0d",
                         c, word_valid, word_out, word_err, err_count, m_present, 16'(m_word), m_err, m_errcnt);
            end
            tick();
        end
    endtask

    initial begin
        resetn     = 1'b0;
        seg_in     = 7'h7F;
        seg_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        m_present  = 0; m_n = 0; m_word = 0; m_err = 0; m_errcnt = 0;
        test_reset();
        test_basic_word();
        test_all_legal();
        test_illegal();
        test_backpressure();
        test_clear();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
